// File: rtl/instr_encoder.sv
// Packs ARM field tuples into instruction words and streams them into memory.
// Optional tuple legality checking is enabled with `define ENC_CHECK_EN.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_cond,
    input  logic [1:0]        in_op,
    input  logic [5:0]        in_funct,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    output logic              mem_we,
    output logic [31:0]       mem_adr,
    output logic [31:0]       mem_wd,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     wd_q, wd_d;
    logic [ADDR_W:0] count_q, count_d;
    logic [ADDR_W:0] count_inc;
    logic            full_q, full_d;
    logic            last_q, last_d;
    logic            reject;
    logic            take;

    assign count_inc = count_q + 1'b1;
    assign take      = (state_q == S_ACCEPT) && in_valid;

`ifdef ENC_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        reject = 1'b0;
        case (in_op)
            2'b11: reject = 1'b1;
            2'b00: begin
                case (in_funct[4:1])
                    4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001: reject = 1'b0;
                    default:                                     reject = 1'b1;
                endcase
            end
            2'b10:   reject = (in_funct[5:4] != 2'b10);
            default: reject = 1'b0;
        endcase
        err_d = take && reject;
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wd_d    = wd_q;
        count_d = count_q;
        full_d  = full_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d = '0;
                    full_d  = 1'b0;
                    adr_d   = BASE_ADDR;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                // A rejected tuple is still consumed; in_last on it ends the load without a write.
                if (take) begin
                    if (reject) begin
                        if (in_last) state_d = S_DONE;
                    end else begin
                        wd_d    = {in_cond, in_op, in_funct, in_rn, in_rd, in_src2};
                        last_d  = in_last;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    count_d = count_inc;
                    adr_d   = adr_q + 32'd4;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (count_inc == (ADDR_W + 1)'(DEPTH)) begin
                        full_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            adr_q   <= BASE_ADDR;
            wd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wd_q    <= wd_d;
            count_q <= count_d;
            full_q  <= full_d;
            last_q  <= last_d;
        end
    end

    assign in_ready = (state_q == S_ACCEPT);
    assign mem_we   = (state_q == S_WRITE);
    assign done     = (state_q == S_DONE);
    assign mem_adr  = adr_q;
    assign mem_wd   = wd_q;
    assign count    = count_q;
    assign full     = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a 64-word instance (index 0) and a 4-word instance (index 1)
// checked against an arithmetic encoding model and a per-instance word counter.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a[2], valid_a[2], last_a[2], ack_a[2];
    logic [3:0]  cond_a[2], rn_a[2], rd_a[2];
    logic [1:0]  op_a[2];
    logic [5:0]  funct_a[2];
    logic [11:0] src2_a[2];
    logic        ready_a[2], we_a[2], done_a[2], full_a[2], err_a[2];
    logic [31:0] adr_a[2], wd_a[2];
    logic [6:0]  count_l;
    logic [2:0]  count_s;

    int checks = 0;
    int errors = 0;

    int unsigned depth_m[2];
    int unsigned cnt_m[2];
    bit          ended_m[2];

    instr_encoder #(.ADDR_W(6), .BASE_ADDR(32'h0)) dut_l (
        .clk(clk), .reset(reset), .start(start_a[0]), .in_valid(valid_a[0]),
        .in_ready(ready_a[0]), .in_last(last_a[0]), .in_cond(cond_a[0]),
        .in_op(op_a[0]), .in_funct(funct_a[0]), .in_rn(rn_a[0]), .in_rd(rd_a[0]),
        .in_src2(src2_a[0]), .mem_we(we_a[0]), .mem_adr(adr_a[0]), .mem_wd(wd_a[0]),
        .mem_ack(ack_a[0]), .count(count_l), .done(done_a[0]), .full(full_a[0]),
        .err(err_a[0])
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut_s (
        .clk(clk), .reset(reset), .start(start_a[1]), .in_valid(valid_a[1]),
        .in_ready(ready_a[1]), .in_last(last_a[1]), .in_cond(cond_a[1]),
        .in_op(op_a[1]), .in_funct(funct_a[1]), .in_rn(rn_a[1]), .in_rd(rd_a[1]),
        .in_src2(src2_a[1]), .mem_we(we_a[1]), .mem_adr(adr_a[1]), .mem_wd(wd_a[1]),
        .mem_ack(ack_a[1]), .count(count_s), .done(done_a[1]), .full(full_a[1]),
        .err(err_a[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int sel);
        return (sel == 1) ? 32'(count_s) : 32'(count_l);
    endfunction

    // Reference encoding: weighted sum of the fields at their bit positions.
    function automatic logic [31:0] enc_word(input logic [3:0] c, input logic [1:0] o,
                                             input logic [5:0] f, input logic [3:0] rn,
                                             input logic [3:0] rd, input logic [11:0] s2);
        int unsigned w;
        w = int'(c) * 32'h1000_0000 + int'(o) * 32'h0400_0000 + int'(f) * 32'h0010_0000
          + int'(rn) * 32'h0001_0000 + int'(rd) * 32'h0000_1000 + int'(s2);
        return w;
    endfunction

    function automatic bit legal(input logic [1:0] o, input logic [5:0] f);
`ifdef ENC_CHECK_EN
        logic [3:0] k;
        k = f[4:1];
        if (o == 2'b11) return 1'b0;
        if (o == 2'b00) return (k == 4'b0100) || (k == 4'b0010) || (k == 4'b0000)
                            || (k == 4'b1100) || (k == 4'b0001);
        if (o == 2'b10) return f[5:4] == 2'b10;
        return 1'b1;
`else
        return (o == o) && (f == f);
`endif
    endfunction

    task automatic start_load(input int sel);
        start_a[sel] = 1'b1;
        step();
        start_a[sel] = 1'b0;
        cnt_m[sel]   = 0;
        ended_m[sel] = 1'b0;
        check("start_ready", 32'(ready_a[sel]), 32'd1);
        check("start_count", cnt_of(sel), 32'd0);
        check("start_adr", adr_a[sel], 32'h0);
        check("start_done", 32'(done_a[sel]), 32'd0);
        check("start_full", 32'(full_a[sel]), 32'd0);
    endtask

    task automatic send(input int sel, input logic [3:0] c, input logic [1:0] o,
                        input logic [5:0] f, input logic [3:0] rn, input logic [3:0] rd,
                        input logic [11:0] s2, input bit last, input int dly);
        logic [31:0] exp_w, exp_a;
        exp_w = enc_word(c, o, f, rn, rd, s2);
        exp_a = 32'(cnt_m[sel] * 4);
        check("send_ready", 32'(ready_a[sel]), 32'd1);
        cond_a[sel] = c; op_a[sel] = o; funct_a[sel] = f;
        rn_a[sel] = rn; rd_a[sel] = rd; src2_a[sel] = s2;
        last_a[sel] = last; valid_a[sel] = 1'b1;
        step();
        valid_a[sel] = 1'b0;
        last_a[sel]  = 1'b0;
        if (!legal(o, f)) begin
            check("rej_err", 32'(err_a[sel]), 32'd1);
            check("rej_we", 32'(we_a[sel]), 32'd0);
            check("rej_ready", 32'(ready_a[sel]), last ? 32'd0 : 32'd1);
            check("rej_done", 32'(done_a[sel]), last ? 32'd1 : 32'd0);
            check("rej_count", cnt_of(sel), 32'(cnt_m[sel]));
            if (last) ended_m[sel] = 1'b1;
            step();
            check("rej_err_pulse", 32'(err_a[sel]), 32'd0);
            return;
        end
        check("wr_we", 32'(we_a[sel]), 32'd1);
        check("wr_adr", adr_a[sel], exp_a);
        check("wr_wd", wd_a[sel], exp_w);
        check("wr_ready", 32'(ready_a[sel]), 32'd0);
        check("wr_err", 32'(err_a[sel]), 32'd0);
        for (int i = 0; i < dly; i++) begin
            step();
            check("hold_we", 32'(we_a[sel]), 32'd1);
            check("hold_adr", adr_a[sel], exp_a);
            check("hold_wd", wd_a[sel], exp_w);
            check("hold_ready", 32'(ready_a[sel]), 32'd0);
            check("hold_count", cnt_of(sel), 32'(cnt_m[sel]));
        end
        ack_a[sel] = 1'b1;
        step();
        ack_a[sel] = 1'b0;
        cnt_m[sel]++;
        check("ack_count", cnt_of(sel), 32'(cnt_m[sel]));
        check("ack_we", 32'(we_a[sel]), 32'd0);
        if (last) begin
            ended_m[sel] = 1'b1;
            check("last_done", 32'(done_a[sel]), 32'd1);
            check("last_full", 32'(full_a[sel]), 32'd0);
            check("last_ready", 32'(ready_a[sel]), 32'd0);
        end else if (cnt_m[sel] == depth_m[sel]) begin
            ended_m[sel] = 1'b1;
            check("cap_full", 32'(full_a[sel]), 32'd1);
            check("cap_done", 32'(done_a[sel]), 32'd1);
            check("cap_ready", 32'(ready_a[sel]), 32'd0);
        end else begin
            check("next_ready", 32'(ready_a[sel]), 32'd1);
            check("next_done", 32'(done_a[sel]), 32'd0);
        end
    endtask

    initial begin
        depth_m[0] = 64;
        depth_m[1] = 4;
        for (int s = 0; s < 2; s++) begin
            start_a[s] = 1'b0; valid_a[s] = 1'b0; last_a[s] = 1'b0; ack_a[s] = 1'b0;
            cond_a[s] = '0; op_a[s] = '0; funct_a[s] = '0;
            rn_a[s] = '0; rd_a[s] = '0; src2_a[s] = '0;
        end
        reset = 1'b1;
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", 32'(ready_a[s]), 32'd0);
            check("rst_we", 32'(we_a[s]), 32'd0);
            check("rst_adr", adr_a[s], 32'h0);
            check("rst_wd", wd_a[s], 32'h0);
            check("rst_count", cnt_of(s), 32'd0);
            check("rst_done", 32'(done_a[s]), 32'd0);
            check("rst_full", 32'(full_a[s]), 32'd0);
            check("rst_err", 32'(err_a[s]), 32'd0);
        end
        reset = 1'b0;
        step();
        check("idle_ready", 32'(ready_a[0]), 32'd0);

        // ADD R1,R2,#5
        start_load(0);
        send(0, 4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 12'h005, 1'b1, 0);
        check("add_word", wd_a[0], 32'hE282_1005);

        // LDR then B -8
        start_load(0);
        send(0, 4'hE, 2'b01, 6'b011001, 4'h1, 4'h0, 12'h004, 1'b0, 0);
        send(0, 4'hE, 2'b10, 6'b101111, 4'hF, 4'hF, 12'hFFE, 1'b1, 0);
        check("b_word", wd_a[0], 32'hEAFF_FFFE);
        check("b_count", cnt_of(0), 32'd2);

        // Delayed ack, plus ack/start ignored while accepting
        start_load(0);
        ack_a[0] = 1'b1;
        step();
        ack_a[0] = 1'b0;
        check("stray_ack_count", cnt_of(0), 32'd0);
        check("stray_ack_ready", 32'(ready_a[0]), 32'd1);
        send(0, 4'h1, 2'b01, 6'b000001, 4'h3, 4'h4, 12'h123, 1'b0, 3);
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        check("start_in_accept_count", cnt_of(0), 32'd1);
        check("start_in_accept_adr", adr_a[0], 32'h4);
        send(0, 4'h0, 2'b00, 6'b001000, 4'h5, 4'h6, 12'hABC, 1'b1, 2);
        valid_a[0] = 1'b1;
        step();
        valid_a[0] = 1'b0;
        check("valid_in_done_we", 32'(we_a[0]), 32'd0);
        check("valid_in_done_count", cnt_of(0), 32'd2);
        check("valid_in_done_done", 32'(done_a[0]), 32'd1);

        // Capacity on the 4-word instance
        start_load(1);
        for (int i = 0; i < 4; i++)
            send(1, 4'hE, 2'b00, 6'b101000, 4'(i), 4'(i + 1), 12'(i * 3), 1'b0, $urandom_range(0, 2));
        valid_a[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("over_ready", 32'(ready_a[1]), 32'd0);
            check("over_we", 32'(we_a[1]), 32'd0);
            check("over_count", cnt_of(1), 32'd4);
        end
        valid_a[1] = 1'b0;
        start_load(1);
        for (int i = 0; i < 4; i++)
            send(1, 4'hA, 2'b01, 6'b011001, 4'h7, 4'(i), 12'h010, i == 3, 0);

        // Reset during a pending write
        start_load(0);
        cond_a[0] = 4'hE; op_a[0] = 2'b01; funct_a[0] = 6'b011001;
        rn_a[0] = 4'h2; rd_a[0] = 4'h3; src2_a[0] = 12'h008; valid_a[0] = 1'b1;
        step();
        valid_a[0] = 1'b0;
        check("pre_rst_we", 32'(we_a[0]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_we", 32'(we_a[0]), 32'd0);
        check("mid_rst_count", cnt_of(0), 32'd0);
        check("mid_rst_adr", adr_a[0], 32'h0);
        step();
        check("mid_rst_idle", 32'(ready_a[0]), 32'd0);
        start_load(0);
        send(0, 4'hE, 2'b01, 6'b011001, 4'h2, 4'h3, 12'h008, 1'b1, 1);

`ifdef ENC_CHECK_EN
        start_load(0);
        send(0, 4'hE, 2'b11, 6'b000000, 4'h1, 4'h1, 12'h001, 1'b0, 0);
        send(0, 4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 12'h005, 1'b0, 0);
        send(0, 4'hE, 2'b00, 6'b011110, 4'h2, 4'h1, 12'h005, 1'b1, 0);
        check("rej_last_count", cnt_of(0), 32'd1);
`endif

        // Randomized programs
        for (int p = 0; p < 8; p++) begin
            int unsigned len;
            len = $urandom_range(1, 10);
            start_load(0);
            for (int unsigned i = 0; i < len && !ended_m[0]; i++)
                send(0, 4'($urandom), 2'($urandom), 6'($urandom), 4'($urandom),
                     4'($urandom), 12'($urandom), i == len - 1, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
